// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - fixed-latency main-memory model behind one L1 cache port
// Optional out-of-range checking on upper address bits: define MEM_BOUNDS_CHECK_EN.
module mem_bus_responder #(
  parameter int          LINE_BITS   = 256,
  parameter int          DEPTH_LINES = 4096,
  parameter int          LATENCY     = 4,
  parameter logic [63:0] RESET_PC    = 64'h100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [63:0]          req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic [LINE_BITS-1:0] resp_rdata,
  output logic                 mem_ready,
  output logic                 resp_error
);

  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam int AW  = $clog2(DEPTH_LINES);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESPOND,
    S_COOLDOWN
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_write;
  logic                   r_oob;
  logic [AW-1:0]          r_idx;
  logic [LINE_BITS-1:0]   r_wdata;
  logic                   r_mem_ready;
  logic                   r_resp_error;
  logic [LINE_BITS-1:0]   r_resp_rdata;
  logic [LINE_BITS-1:0]   r_ram [DEPTH_LINES];

  logic [AW-1:0]          w_in_idx;
  logic                   w_in_oob;
  logic                   w_go_respond;
  logic                   w_rsp_write;
  logic                   w_rsp_oob;
  logic [AW-1:0]          w_rd_idx;
  logic [LINE_BITS-1:0]   w_rd_data;
  logic                   w_unused_bits;

  assign w_in_idx = req_addr[OFF+AW-1:OFF];

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_in_oob = |req_addr[63:OFF+AW];
`else
  assign w_in_oob = 1'b0;
`endif

  assign w_unused_bits = ^{req_addr[OFF-1:0], req_addr[63:OFF+AW], RESET_PC};

  // With LATENCY==1 the response is produced straight from IDLE, so the
  // RAM lookup and the response attributes come from the live request.
  assign w_go_respond = ((r_state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                        ((r_state == S_BUSY) && (r_cnt == CW'(1)));
  assign w_rsp_write  = (r_state == S_IDLE) ? req_write : r_write;
  assign w_rsp_oob    = (r_state == S_IDLE) ? w_in_oob  : r_oob;
  assign w_rd_idx     = (r_state == S_IDLE) ? w_in_idx  : r_idx;
  assign w_rd_data    = r_ram[w_rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_oob        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_mem_ready  <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_mem_ready  <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      if (w_go_respond) begin
        r_mem_ready  <= 1'b1;
        r_resp_error <= w_rsp_oob;
        r_resp_rdata <= (w_rsp_write || w_rsp_oob) ? '0 : w_rd_data;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_oob   <= w_in_oob;
            r_idx   <= w_in_idx;
            r_wdata <= req_wdata;
            r_cnt   <= CNT_LOAD;
            r_state <= (LATENCY > 1) ? S_BUSY : S_RESPOND;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_RESPOND;
          end
        end
        S_RESPOND:  r_state <= S_COOLDOWN;
        S_COOLDOWN: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Write commits at the end of RESPOND; an async reset forces IDLE first,
  // so an interrupted writeback never lands.
  always_ff @(posedge clock) begin
    if ((r_state == S_RESPOND) && r_write && !r_oob) begin
      r_ram[r_idx] <= r_wdata;
    end
  end

  assign mem_ready  = r_mem_ready;
  assign resp_error = r_resp_error;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side end of the L1 cache bus: accepts line-fill reads and line writebacks from one L1 cache (instruction or data), services them after a fixed latency from a backing RAM, then pulses mem_ready.
- Sits below cache_L1 in simulation/FPGA tops as the main-memory model; one instance per cache port.

Parameters:
LINE_BITS, 256, cache line width in bits; power of two, >= 64
DEPTH_LINES, 4096, number of lines in backing RAM; power of two
LATENCY, 4, cycles from request acceptance to mem_ready; >= 1
RESET_PC, 64'h100, first line address; informational only, for the preload map

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  requester has a pending request; held until mem_ready seen
req_write  input  1  1 = writeback line, 0 = line fill
req_addr  input  64  byte address; low log2(LINE_BITS/8) bits ignored
req_wdata  input  LINE_BITS  writeback data
resp_rdata  output  LINE_BITS  fill data, valid only while mem_ready=1
mem_ready  output  1  one-cycle completion pulse
resp_error  output  1  out-of-range access flag, valid with mem_ready (optional feature)

Behaviour:
- Clock/reset: single clock; reset asynchronous, active-high.
- OFF = log2(LINE_BITS/8); AW = log2(DEPTH_LINES); line index = req_addr[OFF+AW-1:OFF].
- States: IDLE, BUSY, RESPOND, COOLDOWN.
- Reset values: state=IDLE, mem_ready=0, resp_rdata=0, resp_error=0, counter=0, captured request regs=0. RAM contents are NOT reset.
- IDLE: if req_valid, capture req_write, index, req_wdata (and range flag); load counter=LATENCY-1; go BUSY if LATENCY>1, else RESPOND.
- BUSY: decrement counter each cycle; at counter==1 go RESPOND. Input changes after acceptance are ignored.
- RESPOND (one cycle): mem_ready=1. Read: resp_rdata = RAM[captured index]. Write: RAM[captured index] <= captured wdata at the end of this cycle; resp_rdata=0. Next state COOLDOWN.
- COOLDOWN (one cycle): mem_ready=0; req_valid ignored, so a request still held the cycle after mem_ready is never serviced twice. Next state IDLE.
- Latency: acceptance edge at cycle T puts mem_ready high during cycle T+LATENCY. Minimum back-to-back spacing: LATENCY+2 cycles.
- resp_rdata returns to 0 on every cycle where mem_ready=0.
- Reset mid-operation: in-flight request dropped, no RAM write, mem_ready deasserted immediately (asynchronous), state IDLE.
- req_valid dropping while BUSY: request still completes and pulses mem_ready; a write still commits.
- Same-line write then read: the read returns the newly written data, since the write commits before the next acceptance.
- Upper address bits above OFF+AW are ignored: the address wraps modulo DEPTH_LINES*LINE_BITS/8.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: at acceptance, any nonzero req_addr bit above OFF+AW sets the captured range flag. In RESPOND, resp_error=1, a write is suppressed (RAM unchanged), a read returns all-zero resp_rdata, and mem_ready still pulses.
- Undefined: resp_error tied to 0 and the address wraps as described above.

Test Plan:
- Reset, LATENCY=4, RAM line 8 preloaded 256'hA5; req_valid=1, req_write=0, req_addr=64'h100 accepted at cycle T -> mem_ready=1 only at T+4, resp_rdata=256'hA5, and mem_ready=0 at T+5 even with req_valid still 1.
- Write req_addr=64'h40, req_wdata=256'hDEADBEEF, then read 64'h40 -> read returns 256'hDEADBEEF; back-to-back acceptances are 6 cycles apart.
- Read 64'h105 -> data identical to 64'h100 (offset bits ignored).
- Assert reset at T+2 of a write to 64'h80 -> mem_ready never pulses and a later read of 64'h80 returns the old contents.
- Drop req_valid at T+1 of a read -> mem_ready still pulses at T+4 with correct data.
- With MEM_BOUNDS_CHECK_EN, DEPTH_LINES=4096: write to 64'h20000 -> mem_ready=1, resp_error=1, RAM line 0 unchanged. Without the macro -> line 0 is overwritten and resp_error=0.
